strassen_2x2_core: RTL and testbench

- Arithmetic datapath stage for the Strassen engine.
- Accepts one pair of 2x2 signed matrix operands over a valid/ready handshake.
- Computes the seven Strassen products M1..M7 serially on one shared multiplier, combines them into C = A*B, and presents the result over a valid/ready handshake.
- Sits directly downstream of the operand-fetch/control sequencer; its result feeds the result-memory write stage.

---
 rtl/strassen_2x2_core.sv | 123 ++++++++++++
 tb/tb_strassen_2x2_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/strassen_2x2_core.sv
// Serial 2x2 Strassen multiplier: seven products on one shared multiplier,
// then a single combine cycle, with valid/ready on both operand and result sides.
module strassen_2x2_core #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 2*DATA_W+2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DATA_W-1:0] a_flat,
    input  logic [4*DATA_W-1:0] b_flat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*OUT_W-1:0]  c_flat,
    output logic                busy
);

    localparam int EW = DATA_W + 1;
    localparam int PW = 2*DATA_W + 2;
    localparam int SW = OUT_W + 2;

    typedef enum logic [1:0] {StIdle, StMul, StComb, StDone} state_e;

    state_e                state_q;
    logic [2:0]            mul_idx_q;
    logic [4*DATA_W-1:0]   a_q, b_q;
    logic signed [PW-1:0]  m_q [7];
    logic [4*OUT_W-1:0]    c_q;
    logic                  out_valid_q;
    logic                  busy_q;

    logic signed [EW-1:0]  a11, a12, a21, a22, b11, b12, b21, b22;
    logic signed [EW-1:0]  op_x, op_y;
    logic signed [PW-1:0]  prod;
    logic signed [SW-1:0]  c11_s, c12_s, c21_s, c22_s;

    always_comb begin
        a11 = EW'($signed(a_q[0*DATA_W +: DATA_W]));
        a12 = EW'($signed(a_q[1*DATA_W +: DATA_W]));
        a21 = EW'($signed(a_q[2*DATA_W +: DATA_W]));
        a22 = EW'($signed(a_q[3*DATA_W +: DATA_W]));
        b11 = EW'($signed(b_q[0*DATA_W +: DATA_W]));
        b12 = EW'($signed(b_q[1*DATA_W +: DATA_W]));
        b21 = EW'($signed(b_q[2*DATA_W +: DATA_W]));
        b22 = EW'($signed(b_q[3*DATA_W +: DATA_W]));
    end

    // Operand select for the shared multiplier; mul_idx_q = i-1 for product Mi.
    always_comb begin
        op_x = '0;
        op_y = '0;
        case (mul_idx_q)
            3'd0: begin op_x = a11 + a22; op_y = b11 + b22; end
            3'd1: begin op_x = a21 + a22; op_y = b11;       end
            3'd2: begin op_x = a11;       op_y = b12 - b22; end
            3'd3: begin op_x = a22;       op_y = b21 - b11; end
            3'd4: begin op_x = a11 + a12; op_y = b22;       end
            3'd5: begin op_x = a21 - a11; op_y = b11 + b12; end
            3'd6: begin op_x = a12 - a22; op_y = b21 + b22; end
            default: begin op_x = '0; op_y = '0; end
        endcase
    end

    assign prod = PW'(op_x) * PW'(op_y);

    always_comb begin
        c11_s = SW'(m_q[0]) + SW'(m_q[3]) - SW'(m_q[4]) + SW'(m_q[6]);
        c12_s = SW'(m_q[2]) + SW'(m_q[4]);
        c21_s = SW'(m_q[1]) + SW'(m_q[3]);
        c22_s = SW'(m_q[0]) - SW'(m_q[1]) + SW'(m_q[2]) + SW'(m_q[5]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mul_idx_q   <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < 7; i++) m_q[i] <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q       <= a_flat;
                        b_q       <= b_flat;
                        mul_idx_q <= 3'd0;
                        busy_q    <= 1'b1;
                        state_q   <= StMul;
                    end
                end
                StMul: begin
                    m_q[mul_idx_q] <= prod;
                    mul_idx_q      <= mul_idx_q + 3'd1;
                    if (mul_idx_q == 3'd6) state_q <= StComb;
                end
                StComb: begin
                    // True results fit in 2*DATA_W+1 bits, so truncation is exact.
                    c_q         <= {OUT_W'(c22_s), OUT_W'(c21_s), OUT_W'(c12_s), OUT_W'(c11_s)};
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign c_flat    = c_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_strassen_2x2_core.sv
// Directed bench for strassen_2x2_core: latency, extremes, stalls, reset abort,
// back-to-back throughput and a random sweep against a direct 2x2 product.
module tb_strassen_2x2_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_flat;
    logic [31:0] b_flat;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] c_flat;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    strassen_2x2_core #(.DATA_W(8), .OUT_W(18)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_flat    (c_flat),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mat(input int x11, input int x12, input int x21, input int x22);
        return {8'(x22), 8'(x21), 8'(x12), 8'(x11)};
    endfunction

    function automatic logic [71:0] pk(input int c11, input int c12, input int c21, input int c22);
        return {18'(c22), 18'(c21), 18'(c12), 18'(c11)};
    endfunction

    function automatic logic [71:0] model(input logic [31:0] a, input logic [31:0] b);
        int x11, x12, x21, x22, y11, y12, y21, y22;
        x11 = $signed(a[7:0]);   x12 = $signed(a[15:8]);
        x21 = $signed(a[23:16]); x22 = $signed(a[31:24]);
        y11 = $signed(b[7:0]);   y12 = $signed(b[15:8]);
        y21 = $signed(b[23:16]); y22 = $signed(b[31:24]);
        return pk(x11*y11 + x12*y21, x11*y12 + x12*y22,
                  x21*y11 + x22*y21, x21*y12 + x22*y22);
    endfunction

    // Present operands, wait (bounded) for in_ready, return just after the accept edge.
    task automatic start(input logic [31:0] a, input logic [31:0] b, output int acc);
        int n;
        in_valid = 1'b1;
        a_flat   = a;
        b_flat   = b;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_timeout", in_ready, 1'b1);
        tick();
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk(tag, out_valid, 1'b1);
    endtask

    initial begin
        logic [31:0] qa [3];
        logic [31:0] qb [3];
        int          acc [3];
        int          k;
        bit          seen;
        bit          done;
        bit          fire;
        int          n;
        logic [31:0] ra, rb;
        logic [71:0] exp_c;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_flat    = '0;
        b_flat    = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_c_flat", c_flat, 72'd0);

        // Basic product and latency: out_valid rises exactly 8 edges after accept.
        start(mat(1, 2, 3, 4), mat(5, 6, 7, 8), k);
        chk("busy_after_accept", busy, 1'b1);
        repeat (7) tick();
        chk("lat_not_early", out_valid, 1'b0);
        tick();
        chk("lat_valid", out_valid, 1'b1);
        chk("basic_c", c_flat, pk(19, 22, 43, 50));
        tick();
        chk("basic_release_valid", out_valid, 1'b0);
        chk("basic_release_ready", in_ready, 1'b1);

        // Extremes.
        start({4{8'h80}}, {4{8'h80}}, k);
        wait_valid("neg_timeout");
        chk("neg_c", c_flat, pk(32768, 32768, 32768, 32768));
        tick();
        start({4{8'h80}}, {4{8'h7f}}, k);
        wait_valid("mix_timeout");
        chk("mix_c", c_flat, pk(-32512, -32512, -32512, -32512));
        tick();

        // Output stall with in_valid asserted: nothing accepted, result held.
        out_ready = 1'b0;
        start(mat(2, -1, 0, 3), mat(1, 4, -2, 5), k);
        wait_valid("stall_timeout");
        chk("stall_c0", c_flat, pk(4, 3, -6, 15));
        in_valid = 1'b1;
        a_flat   = mat(7, 7, 7, 7);
        b_flat   = mat(7, 7, 7, 7);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_c", c_flat, pk(4, 3, -6, 15));
            chk("stall_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall_release_ready", in_ready, 1'b1);
        chk("stall_release_valid", out_valid, 1'b0);

        // Reset during MUL with mul_idx=3 aborts the job.
        start(mat(1, 2, 3, 4), mat(5, 6, 7, 8), k);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", seen, 1'b0);
        start(mat(1, 0, 0, 1), mat(9, -3, 4, 7), k);
        wait_valid("ident_timeout");
        chk("ident_c", c_flat, pk(9, -3, 4, 7));
        tick();

        // Back-to-back jobs with in_valid held high: accepts 10 cycles apart.
        for (int j = 0; j < 3; j++) begin
            qa[j] = $urandom;
            qb[j] = $urandom;
        end
        in_valid = 1'b1;
        a_flat   = qa[0];
        b_flat   = qb[0];
        for (int j = 0; j < 3; j++) begin
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            chk("q_accept_timeout", in_ready, 1'b1);
            tick();
            acc[j] = cyc;
            if (j < 2) begin
                a_flat = qa[j+1];
                b_flat = qb[j+1];
            end else begin
                in_valid = 1'b0;
            end
            wait_valid("q_timeout");
            chk("q_c", c_flat, model(qa[j], qb[j]));
            if (j > 0) chk("q_gap", 72'(acc[j] - acc[j-1]), 72'd10);
        end
        tick();

        // Random sweep with random output stalls and operand churn after capture.
        for (int j = 0; j < 1000; j++) begin
            ra    = $urandom;
            rb    = $urandom;
            exp_c = model(ra, rb);
            start(ra, rb, k);
            a_flat = $urandom;
            b_flat = $urandom;
            seen = 1'b0;
            done = 1'b0;
            n    = 0;
            while (!done && n < 200) begin
                if (out_valid && !seen) begin
                    chk("rnd_c", c_flat, exp_c);
                    seen = 1'b1;
                end
                out_ready = 1'($urandom_range(0, 1));
                fire = out_valid && out_ready;
                tick();
                n++;
                if (fire) done = 1'b1;
            end
            chk("rnd_handshake", done, 1'b1);
            chk("rnd_no_dup", out_valid, 1'b0);
        end
        out_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
